// File: rtl/cpu_pkg.sv
// Shared definitions for the Mini SRC hardwired control unit.
// Defines opcode constants, ALU function encodings and the sequencer state type.
package cpu_pkg;

    localparam logic [4:0] OP_NOP  = 5'b00000;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_SHR  = 5'b00101;
    localparam logic [4:0] OP_SHL  = 5'b00110;
    localparam logic [4:0] OP_ROR  = 5'b00111;
    localparam logic [4:0] OP_ROL  = 5'b01000;
    localparam logic [4:0] OP_AND  = 5'b01001;
    localparam logic [4:0] OP_OR   = 5'b01010;
    localparam logic [4:0] OP_MUL  = 5'b01110;
    localparam logic [4:0] OP_DIV  = 5'b01111;
    localparam logic [4:0] OP_HALT = 5'b11011;

    localparam logic [3:0] ALU_NONE = 4'd0;
    localparam logic [3:0] ALU_ADD  = 4'd1;
    localparam logic [3:0] ALU_SUB  = 4'd2;
    localparam logic [3:0] ALU_SHR  = 4'd3;
    localparam logic [3:0] ALU_SHL  = 4'd4;
    localparam logic [3:0] ALU_ROR  = 4'd5;
    localparam logic [3:0] ALU_ROL  = 4'd6;
    localparam logic [3:0] ALU_AND  = 4'd7;
    localparam logic [3:0] ALU_OR   = 4'd8;
    localparam logic [3:0] ALU_MUL  = 4'd9;
    localparam logic [3:0] ALU_DIV  = 4'd10;

    typedef enum logic [3:0] {
        ST_RST,
        ST_T0,
        ST_T1,
        ST_T1W,
        ST_T2,
        ST_T3,
        ST_T4,
        ST_T5,
        ST_T6,
        ST_HALT
    } state_t;

endpackage

// File: rtl/opcode_decoder.sv
// Combinational opcode classifier for the control sequencer.
// MUL/DIV are recognised only when CTRL_MULDIV_EN is defined.
module opcode_decoder
    import cpu_pkg::*;
#(
    parameter int OPW = 5
) (
    input  logic [OPW-1:0] i_opcode,
    output logic [3:0]     o_alu_op,
    output logic           o_is_alu,
    output logic           o_is_muldiv,
    output logic           o_is_halt,
    output logic           o_is_nop
);

    always_comb begin
        o_alu_op    = ALU_NONE;
        o_is_alu    = 1'b0;
        o_is_muldiv = 1'b0;
        o_is_halt   = 1'b0;
        o_is_nop    = 1'b0;
        case (i_opcode)
            OP_ADD:  begin o_alu_op = ALU_ADD; o_is_alu = 1'b1; end
            OP_SUB:  begin o_alu_op = ALU_SUB; o_is_alu = 1'b1; end
            OP_SHR:  begin o_alu_op = ALU_SHR; o_is_alu = 1'b1; end
            OP_SHL:  begin o_alu_op = ALU_SHL; o_is_alu = 1'b1; end
            OP_ROR:  begin o_alu_op = ALU_ROR; o_is_alu = 1'b1; end
            OP_ROL:  begin o_alu_op = ALU_ROL; o_is_alu = 1'b1; end
            OP_AND:  begin o_alu_op = ALU_AND; o_is_alu = 1'b1; end
            OP_OR:   begin o_alu_op = ALU_OR;  o_is_alu = 1'b1; end
`ifdef CTRL_MULDIV_EN
            OP_MUL:  begin o_alu_op = ALU_MUL; o_is_muldiv = 1'b1; end
            OP_DIV:  begin o_alu_op = ALU_DIV; o_is_muldiv = 1'b1; end
`endif
            OP_HALT: o_is_halt = 1'b1;
            OP_NOP:  o_is_nop  = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired Moore control unit driving the Mini SRC datapath strobes per T-state.
// Optional feature macro: CTRL_MULDIV_EN (MUL/DIV execute through T6).
module control_sequencer
    import cpu_pkg::*;
#(
    parameter int OPW = 5,
    parameter int RFW = 4
) (
    input  logic        Clock,
    input  logic        Resetn,
    input  logic [31:0] IR,
    input  logic        Mem_ready,
    input  logic        Stop,
    output logic        PCout,
    output logic        Zlowout,
    output logic        Zhighout,
    output logic        MDRout,
    output logic        Rout,
    output logic        MARin,
    output logic        PCin,
    output logic        MDRin,
    output logic        IRin,
    output logic        Yin,
    output logic        Zin,
    output logic        Rin,
    output logic        LOin,
    output logic        HIin,
    output logic        IncPC,
    output logic        Read,
    output logic        Gra,
    output logic        Grb,
    output logic        Grc,
    output logic [3:0]  ALU_op,
    output logic        Run,
    output logic        Illegal
);

    state_t     r_state, w_next;
    logic       r_stop;
    logic       w_stop_req;
    logic [3:0] w_alu_op;
    logic       w_is_alu, w_is_muldiv, w_is_halt, w_is_nop;
    logic       w_lo_in, w_hi_in, w_zhigh_out;

    logic [31-OPW:0] w_unused_ir;
    logic [RFW-1:0]  w_unused_ra;
    assign w_unused_ir = IR[31-OPW:0];
    assign w_unused_ra = IR[31-OPW -: RFW];

    opcode_decoder #(.OPW(OPW)) u_dec (
        .i_opcode    (IR[31 -: OPW]),
        .o_alu_op    (w_alu_op),
        .o_is_alu    (w_is_alu),
        .o_is_muldiv (w_is_muldiv),
        .o_is_halt   (w_is_halt),
        .o_is_nop    (w_is_nop)
    );

    // A Stop seen mid-instruction is remembered until the instruction boundary.
    assign w_stop_req = Stop | r_stop;

    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            r_state <= ST_RST;
            r_stop  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_stop  <= r_stop | Stop;
        end
    end

    always_comb begin
        w_next      = r_state;
        PCout       = 1'b0;
        Zlowout     = 1'b0;
        MDRout      = 1'b0;
        Rout        = 1'b0;
        MARin       = 1'b0;
        PCin        = 1'b0;
        MDRin       = 1'b0;
        IRin        = 1'b0;
        Yin         = 1'b0;
        Zin         = 1'b0;
        Rin         = 1'b0;
        IncPC       = 1'b0;
        Read        = 1'b0;
        Gra         = 1'b0;
        Grb         = 1'b0;
        Grc         = 1'b0;
        ALU_op      = ALU_NONE;
        Illegal     = 1'b0;
        w_lo_in     = 1'b0;
        w_hi_in     = 1'b0;
        w_zhigh_out = 1'b0;
        Run         = (r_state != ST_RST) && (r_state != ST_HALT);
        case (r_state)
            ST_RST: w_next = ST_T0;
            ST_T0: begin
                PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1;
                w_next = ST_T1;
            end
            ST_T1: begin
                Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1;
                w_next = Mem_ready ? ST_T2 : ST_T1W;
            end
            ST_T1W: begin
                Read = 1'b1; MDRin = 1'b1;
                if (Mem_ready) w_next = ST_T2;
            end
            ST_T2: begin
                MDRout = 1'b1; IRin = 1'b1;
                w_next = ST_T3;
            end
            ST_T3: begin
                if (w_is_alu) begin
                    Grb = 1'b1; Rout = 1'b1; Yin = 1'b1;
                    w_next = ST_T4;
                end else if (w_is_muldiv) begin
                    Gra = 1'b1; Rout = 1'b1; Yin = 1'b1;
                    w_next = ST_T4;
                end else if (w_is_halt) begin
                    w_next = ST_HALT;
                end else begin
                    Illegal = !w_is_nop;
                    w_next  = w_stop_req ? ST_HALT : ST_T0;
                end
            end
            ST_T4: begin
                Rout = 1'b1; Zin = 1'b1; ALU_op = w_alu_op;
                Grb  = w_is_muldiv;
                Grc  = !w_is_muldiv;
                w_next = ST_T5;
            end
            ST_T5: begin
                Zlowout = 1'b1;
                if (w_is_muldiv) begin
                    w_lo_in = 1'b1;
                    w_next  = ST_T6;
                end else begin
                    Gra = 1'b1; Rin = 1'b1;
                    w_next = w_stop_req ? ST_HALT : ST_T0;
                end
            end
            ST_T6: begin
                w_zhigh_out = 1'b1; w_hi_in = 1'b1;
                w_next = w_stop_req ? ST_HALT : ST_T0;
            end
            ST_HALT: w_next = ST_HALT;
            default: w_next = ST_RST;
        endcase
    end

    // Without MUL/DIV the decoder never flags muldiv, so T6 is unreachable.
`ifdef CTRL_MULDIV_EN
    assign LOin     = w_lo_in;
    assign HIin     = w_hi_in;
    assign Zhighout = w_zhigh_out;
`else
    logic w_unused_md;
    assign w_unused_md = w_lo_in | w_hi_in | w_zhigh_out;
    assign LOin        = 1'b0;
    assign HIin        = 1'b0;
    assign Zhighout    = 1'b0;
`endif

endmodule
